input_route_unit: RTL
=====================

INPUT_ROUTE_UNIT -- requirements
Module: input_route_unit

Interface
- REQ-001 Parameter DATA_W, default 16, flit payload width; flit = {type[1:0], payload[DATA_W-1:0]}.
- REQ-002 Parameter DEPTH, default 4, input FIFO depth in flits; power of two, minimum 2.
- REQ-003 Parameter LOCAL_X, default 0, 2-bit X coordinate of this router.
- REQ-004 Parameter LOCAL_Y, default 0, 2-bit Y coordinate of this router.
- REQ-005 clk  in  1  single clock; all state updates on rising edge.
- REQ-006 rst_n  in  1  reset, asynchronous, active-high: rst_n=1 resets; the name is kept for codebase consistency.
- REQ-007 in_valid  in  1  upstream flit valid.
- REQ-008 in_ready  out  1  FIFO can accept a flit.
- REQ-009 in_flit  in  DATA_W+2  incoming flit.
- REQ-010 req  out  1  output-port request to the downstream conflict handler.
- REQ-011 route_dim  out  2  requested dimension: 00 none, 01 X, 10 Y, 11 local.
- REQ-012 route_dir  out  1  direction: 1 = increasing coordinate, 0 = decreasing; 0 for local.
- REQ-013 grant  in  1  conflict handler accepts the request.
- REQ-014 out_valid  out  1  flit on out_flit valid.
- REQ-015 out_ready  in  1  downstream accepts the flit.
- REQ-016 out_flit  out  DATA_W+2  outgoing flit, equal to the FIFO head.
- REQ-017 err_cnt  out  8  dropped-flit count (see Configuration).

Function
- REQ-018 Flit type: 01 head, 00 body, 10 tail, 11 single (head+tail); head payload[3:2] = dest X, payload[1:0] = dest Y.
- REQ-019 FIFO push when in_valid && in_ready; in_ready = !full, registered-state based; a flit pushed in cycle N is visible at the head in N+1.
- REQ-020 FSM states IDLE, ROUTE, REQ, XFER; reset state IDLE.
- REQ-021 IDLE: FIFO non-empty, head type 01/11 -> ROUTE; head type 00/10 -> pop and drop (1 flit/cycle), stay IDLE.
- REQ-022 ROUTE (1 cycle): XY routing registered: dest X != LOCAL_X -> dim 01, dir = (dest X > LOCAL_X); else dest Y != LOCAL_Y -> dim 10, dir = (dest Y > LOCAL_Y); else dim 11, dir 0; -> REQ.
- REQ-023 REQ: req=1, route held; grant=1 -> XFER next cycle; grant is ignored outside REQ.
- REQ-024 XFER: req stays 1 (wormhole lock), out_valid = !empty, pop on out_valid && out_ready; popping a type 10/11 flit -> IDLE next cycle with req=0.
- REQ-025 Head latency: head pushed in N, req asserted in N+3, first out_valid in cycle after grant.
- REQ-026 route_dim/route_dir change only in ROUTE; hold last value otherwise.
- REQ-027 Simultaneous push and pop are allowed in any non-full state; count unchanged; pointers wrap modulo DEPTH.
- REQ-028 Empty in XFER mid-packet: out_valid=0, state held, req held.
- REQ-029 A head flit arriving while in XFER is treated as payload of the current packet (no check).

Reset
- REQ-030 On rst_n=1: FSM IDLE, FIFO empty (pointers and count 0), req=0, route_dim=00, route_dir=0, out_valid=0, in_ready=0 while asserted, err_cnt=0.
- REQ-031 Reset mid-packet discards all buffered flits; after release in_ready=1 from the first edge.

Configuration
- REQ-032 Macro ROUTE_ERR_CNT_EN defined: err_cnt increments by 1 per flit dropped in IDLE, saturating at 255.
- REQ-033 Macro ROUTE_ERR_CNT_EN undefined: no counter logic; err_cnt tied to 0; drop behaviour unchanged.

Verification (LOCAL_X=1, LOCAL_Y=1, DEPTH=4)
- REQ-034 Single flit type 11, payload dest (3,1), grant in first REQ cycle -> req=1 three cycles after push, route_dim=01, route_dir=1, one flit out, req=0 after pop.
- REQ-035 Head dest (1,0), 2 body, tail, grant delayed 5 cycles -> route_dim=10, route_dir=0, req held through 4 flits, no out_valid before grant.
- REQ-036 Head dest (1,1) -> route_dim=11, route_dir=0.
- REQ-037 Push 4 flits with out_ready=0 -> in_ready=0 after 4th; one pop with concurrent push -> count stays 4, order preserved across wrap.
- REQ-038 Three body flits with no head, macro defined -> all dropped, err_cnt=3; macro undefined -> err_cnt=0.
- REQ-039 Assert rst_n in XFER after 2 of 4 flits -> req=0, out_valid=0, FIFO empty immediately; next head routed normally.

Source files
------------

// File: rtl/input_route_unit.sv
// Input port of a mesh router: flit FIFO, XY route computation and wormhole
// request/transfer FSM. Headless body/tail flits reaching the FIFO head while
// idle are discarded.
// Optional feature: define ROUTE_ERR_CNT_EN to count discarded flits on err_cnt
// (saturating at 255). Without it err_cnt is tied to zero.
module input_route_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LOCAL_X = 0,
    parameter int unsigned LOCAL_Y = 0
) (
    input  logic              clk,
    input  logic              rst_n,  // active-high asynchronous reset
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W+1:0] in_flit,
    output logic              req,
    output logic [1:0]        route_dim,
    output logic              route_dir,
    input  logic              grant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W+1:0] out_flit,
    output logic [7:0]        err_cnt
);

    localparam int unsigned FlitW = DATA_W + 2;
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);
    localparam logic [1:0] LocX = 2'(LOCAL_X);
    localparam logic [1:0] LocY = 2'(LOCAL_Y);

    typedef enum logic [1:0] {StIdle, StRoute, StReq, StXfer} state_e;

    logic [FlitW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [1:0]       dim_q, dim_d;
    logic             dir_q, dir_d;

    logic             empty, full, push, pop, drop, xfer_pop;
    logic [FlitW-1:0] head;
    logic [1:0]       head_type;
    logic [1:0]       dest_x, dest_y;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FullCnt);
    assign head      = mem_q[rd_ptr_q];
    assign head_type = head[FlitW-1:FlitW-2];
    assign dest_x    = head[3:2];
    assign dest_y    = head[1:0];

    // Refuse input while reset is held so nothing is written into a FIFO being cleared.
    assign in_ready  = !rst_n && !full;
    assign push      = in_valid && in_ready;

    // Idle with a non-head flit at the head: it has no route, discard it.
    assign drop      = (state_q == StIdle) && !empty && !head_type[0];
    assign out_valid = (state_q == StXfer) && !empty;
    assign xfer_pop  = out_valid && out_ready;
    assign pop       = drop || xfer_pop;

    assign out_flit  = head;
    assign req       = req_q;
    assign route_dim = dim_q;
    assign route_dir = dir_q;

    // FIFO pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FSM next-state with registered request and route outputs.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dim_d   = dim_q;
        dir_d   = dir_q;
        case (state_q)
            StIdle: begin
                if (!empty && head_type[0]) state_d = StRoute;
            end
            StRoute: begin
                // Dimension-ordered routing: resolve X first, then Y, else eject locally.
                if (dest_x != LocX) begin
                    dim_d = 2'b01;
                    dir_d = (dest_x > LocX);
                end else if (dest_y != LocY) begin
                    dim_d = 2'b10;
                    dir_d = (dest_y > LocY);
                end else begin
                    dim_d = 2'b11;
                    dir_d = 1'b0;
                end
                req_d   = 1'b1;
                state_d = StReq;
            end
            StReq: begin
                if (grant) state_d = StXfer;
            end
            StXfer: begin
                // Request stays locked until the packet's last flit leaves.
                if (xfer_pop && head_type[1]) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            req_q    <= 1'b0;
            dim_q    <= 2'b00;
            dir_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            req_q    <= req_d;
            dim_q    <= dim_d;
            dir_q    <= dir_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end

`ifdef ROUTE_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Saturating count of flits discarded while idle.
    always_comb begin
        err_d = err_q;
        if (drop && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) err_q <= 8'd0;
        else       err_q <= err_d;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
